// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg -- shared types and helpers for the SPI receive framer.
//   rx_state_e  : framer state encoding (S_DATA, S_CRC, S_DONE)
//   DW_MAX_MIN / DW_MAX_LIM : legal range of the DW_MAX parameter
//   frame_len() : bits per frame for a given dsize (dsize + 1)
//   frame_mask(): right-aligned mask covering dsize + 1 bits
package spi_rx_pkg;

  localparam int DW_MAX_MIN = 8;
  localparam int DW_MAX_LIM = 32;

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_CRC  = 2'd1,
    S_DONE = 2'd2
  } rx_state_e;

  function automatic logic [5:0] frame_len(input logic [4:0] dsize);
    return {1'b0, dsize} + 6'd1;
  endfunction

  // Shifting the complement keeps dsize = 31 from overflowing into a
  // 33-bit intermediate.
  function automatic logic [31:0] frame_mask(input logic [4:0] dsize);
    return ~(32'hFFFF_FFFE << dsize);
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo -- receive FIFO for the SPI framer.
// Ports:
//   clk_rx, spi_rx_rstn : clock, async active-low reset
//   push, push_data     : write a completed frame
//   pop                 : remove the head (ignored while empty)
//   rd_data             : head entry, zero while empty
//   empty, full, level  : occupancy status
//   drop                : a push was refused because the FIFO was full
//                         and no pop freed a slot this cycle
module spi_rx_fifo #(
  parameter int DW_MAX     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_rx,
  input  logic                          spi_rx_rstn,
  input  logic                          push,
  input  logic [DW_MAX-1:0]             push_data,
  input  logic                          pop,
  output logic [DW_MAX-1:0]             rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DW_MAX-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign level   = level_q;
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
    if (!spi_rx_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: rd_data is forced to zero while empty.
  always_ff @(posedge clk_rx) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spi_rx_framer.sv
// spi_rx_framer -- SPI receive framer: assembles serial bits into frames of
// dsize+1 bits, queues them in a FIFO, counts frames per transfer and
// optionally checks a trailing CRC frame.
// Optional feature: define SPI_RX_FRAMER_CRC_EN to build the CRC engine,
// the S_CRC state and crc_err; otherwise crc_en/crc_poly are ignored.
// Ports:
//   clk_rx, spi_rx_rstn : shift clock, async active-low reset / frame sync
//   shift_in            : serial data, sampled on each rising edge
//   dsize, lsbf         : frame length - 1, bit order (latched at bit 0)
//   tnum_max            : data frames per transfer (0 = unlimited)
//   crc_en, crc_poly    : CRC frame enable and polynomial
//   rd_en, rd_data      : FIFO pop and head data
//   fifo_empty/full/level : FIFO status
//   ovr, ovr_clr        : sticky overrun flag and its clear
//   crc_err, rx_done, rx_busy : status flags
//
// state  | meaning
// S_DATA | receiving data frames into the FIFO
// S_CRC  | receiving the CRC frame, compared against the running CRC
// S_DONE | transfer complete, shift_in ignored
module spi_rx_framer
  import spi_rx_pkg::*;
#(
  parameter int DW_MAX     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_rx,
  input  logic                         spi_rx_rstn,
  input  logic                         shift_in,
  input  logic [4:0]                   dsize,
  input  logic                         lsbf,
  input  logic [12:0]                  tnum_max,
  input  logic                         crc_en,
  input  logic [31:0]                  crc_poly,
  input  logic                         rd_en,
  input  logic                         ovr_clr,
  output logic [DW_MAX-1:0]            rd_data,
  output logic                         fifo_empty,
  output logic                         fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         ovr,
  output logic                         crc_err,
  output logic                         rx_done,
  output logic                         rx_busy
);

  rx_state_e         state_q;
  logic [4:0]        bit_cnt_q;
  logic [4:0]        dsize_q;
  logic              lsbf_q;
  logic [DW_MAX-1:0] sr_q;
  logic [12:0]       frame_cnt_q;
  logic              ovr_q;

  logic [4:0]        cur_dsize;
  logic              cur_lsbf;
  logic [DW_MAX-1:0] sr_base;
  logic [DW_MAX-1:0] sr_next;
  logic [DW_MAX-1:0] cur_mask;
  logic              active;
  logic              frame_last;
  logic              push;
  logic              last_data;
  logic              drop;

  // At bit 0 the live inputs apply; later bits use the values latched then.
  always_comb begin
    cur_dsize  = dsize_q;
    cur_lsbf   = lsbf_q;
    sr_base    = sr_q;
    if (bit_cnt_q == '0) begin
      cur_dsize = dsize;
      cur_lsbf  = lsbf;
      sr_base   = '0;
    end
    if (cur_lsbf) sr_next = sr_base | (DW_MAX'(shift_in) << bit_cnt_q);
    else          sr_next = {sr_base[DW_MAX-2:0], shift_in};
    cur_mask   = DW_MAX'(frame_mask(cur_dsize));
    active     = (state_q != S_DONE);
    frame_last = ({1'b0, bit_cnt_q} + 6'd1) == frame_len(cur_dsize);
    push       = active && frame_last && (state_q == S_DATA);
    last_data  = push && (tnum_max != '0) && ((frame_cnt_q + 13'd1) == tnum_max);
  end

`ifdef SPI_RX_FRAMER_CRC_EN
  logic [DW_MAX-1:0] crc_q;
  logic [DW_MAX-1:0] crc_next;
  logic              crc_err_q;
  logic              crc_fb;

  // Serial MSB-first CRC, width dsize+1, initial value zero.
  always_comb begin
    crc_fb   = crc_q[cur_dsize] ^ shift_in;
    crc_next = ((crc_q << 1) ^ (crc_fb ? crc_poly[DW_MAX-1:0] : '0)) & cur_mask;
  end

  always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
    if (!spi_rx_rstn) begin
      crc_q     <= '0;
      crc_err_q <= 1'b0;
    end else begin
      if (state_q == S_DATA) crc_q <= crc_next;
      if (state_q == S_CRC && frame_last)
        crc_err_q <= (sr_next & cur_mask) != (crc_q & cur_mask);
    end
  end

  assign crc_err = crc_err_q;
`else
  logic unused_crc_cfg;
  assign unused_crc_cfg = ^{crc_en, crc_poly, cur_mask};
  assign crc_err        = 1'b0;
`endif

  always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
    if (!spi_rx_rstn) begin
      state_q     <= S_DATA;
      bit_cnt_q   <= '0;
      dsize_q     <= '0;
      lsbf_q      <= 1'b0;
      sr_q        <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (active) begin
        sr_q      <= sr_next;
        bit_cnt_q <= frame_last ? 5'd0 : bit_cnt_q + 5'd1;
        if (bit_cnt_q == '0) begin
          dsize_q <= dsize;
          lsbf_q  <= lsbf;
        end
      end
      if (push) frame_cnt_q <= frame_cnt_q + 13'd1;
      case (state_q)
        S_DATA: begin
          if (last_data) begin
`ifdef SPI_RX_FRAMER_CRC_EN
            state_q <= crc_en ? S_CRC : S_DONE;
`else
            state_q <= S_DONE;
`endif
          end
        end
`ifdef SPI_RX_FRAMER_CRC_EN
        S_CRC: begin
          if (frame_last) state_q <= S_DONE;
        end
`endif
        S_DONE:  state_q <= S_DONE;
        default: state_q <= S_DATA;
      endcase
    end
  end

  // An overrun in the same cycle as ovr_clr keeps the flag set.
  always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
    if (!spi_rx_rstn)  ovr_q <= 1'b0;
    else if (drop)     ovr_q <= 1'b1;
    else if (ovr_clr)  ovr_q <= 1'b0;
  end

  spi_rx_fifo #(
    .DW_MAX     (DW_MAX),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_rx      (clk_rx),
    .spi_rx_rstn (spi_rx_rstn),
    .push        (push),
    .push_data   (sr_next),
    .pop         (rd_en),
    .rd_data     (rd_data),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .level       (fifo_level),
    .drop        (drop)
  );

  assign ovr     = ovr_q;
  assign rx_done = (state_q == S_DONE);
  assign rx_busy = (bit_cnt_q != '0);

endmodule

// File: tb/tb_spi_rx_framer.sv
// Scoreboard bench for spi_rx_framer: stimulus pushes expected FIFO data
// into exp_q, a monitor pops and compares on every accepted read.
module tb_spi_rx_framer;

  logic        clk_rx = 1'b0;
  logic        spi_rx_rstn = 1'b0;
  logic        shift_in = 1'b0;
  logic [4:0]  dsize = 5'd7;
  logic        lsbf = 1'b0;
  logic [12:0] tnum_max = '0;
  logic        crc_en = 1'b0;
  logic [31:0] crc_poly = '0;
  logic        rd_en = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [31:0] rd_data;
  logic        fifo_empty, fifo_full, ovr, crc_err, rx_done, rx_busy;
  logic [2:0]  fifo_level;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

`ifdef SPI_RX_FRAMER_CRC_EN
  localparam bit CRC_BUILT = 1'b1;
`else
  localparam bit CRC_BUILT = 1'b0;
`endif

  spi_rx_framer #(.DW_MAX(32), .FIFO_DEPTH(4)) dut (
    .clk_rx(clk_rx), .spi_rx_rstn(spi_rx_rstn), .shift_in(shift_in),
    .dsize(dsize), .lsbf(lsbf), .tnum_max(tnum_max), .crc_en(crc_en),
    .crc_poly(crc_poly), .rd_en(rd_en), .ovr_clr(ovr_clr),
    .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .ovr(ovr), .crc_err(crc_err),
    .rx_done(rx_done), .rx_busy(rx_busy)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a read is accepted when rd_en is high and the FIFO non-empty
  // at the sampling point ahead of the rising edge.
  initial begin
    forever begin
      @(negedge clk_rx);
      if (spi_rx_rstn && rd_en && !fifo_empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop: got 0x%0h expected no data", rd_data);
        end else begin
          check("rd_data_pop", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_data"}, rd_data, 32'h0);
    check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    check({tag, "_full"}, 32'(fifo_full), 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_ovr"}, 32'(ovr), 32'd0);
    check({tag, "_crc_err"}, 32'(crc_err), 32'd0);
    check({tag, "_rx_done"}, 32'(rx_done), 32'd0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_rx);
    spi_rx_rstn = 1'b0;
    rd_en = 1'b0;
    ovr_clr = 1'b0;
    @(posedge clk_rx);
    #1;
    check_reset_vals(tag);
    @(negedge clk_rx);
    spi_rx_rstn = 1'b1;
  endtask

  task automatic send_bit(input logic b, input int n, input logic lsb);
    dsize = 5'(n);
    lsbf = lsb;
    shift_in = b;
    @(posedge clk_rx);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] v, input int n, input logic lsb, input logic rd_last);
    for (int i = 0; i <= n; i++) begin
      if (i == n) rd_en = rd_last;
      send_bit(lsb ? v[i] : v[n - i], n, lsb);
      rd_en = 1'b0;
    end
  endtask

  task automatic rd_pulse();
    rd_en = 1'b1;
    @(posedge clk_rx);
    #1;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] bits_a5;
    bits_a5 = 8'b1010_0101;

    // 8-bit MSB-first 0xA5
    tnum_max = 13'd1;
    crc_en = 1'b0;
    do_reset("rst0");
    for (int i = 0; i < 8; i++) begin
      send_bit(bits_a5[7 - i], 7, 1'b0);
      if (i == 3) check("a5_busy_mid", 32'(rx_busy), 32'd1);
    end
    check("a5_empty", 32'(fifo_empty), 32'd0);
    check("a5_head", rd_data, 32'h0000_00A5);
    check("a5_level", 32'(fifo_level), 32'd1);
    check("a5_done", 32'(rx_done), 32'd1);
    check("a5_busy_end", 32'(rx_busy), 32'd0);
    exp_q.push_back(32'h0000_00A5);
    rd_pulse();
    check("a5_empty_after", 32'(fifo_empty), 32'd1);
    check("a5_rd_zero", rd_data, 32'h0);

    // 12-bit LSB-first 0xABC
    do_reset("rst1");
    send_frame(32'h0000_0ABC, 11, 1'b1, 1'b0);
    check("abc_head", rd_data, 32'h0000_0ABC);
    exp_q.push_back(32'h0000_0ABC);
    rd_pulse();

    // Overrun: five frames into a 4-deep FIFO
    tnum_max = 13'd5;
    do_reset("rst2");
    for (int f = 1; f <= 5; f++) begin
      send_frame(32'(f), 7, 1'b0, 1'b0);
      if (f == 4) begin
        check("ovr_full4", 32'(fifo_full), 32'd1);
        check("ovr_level4", 32'(fifo_level), 32'd4);
        check("ovr_pre", 32'(ovr), 32'd0);
      end
      if (f <= 4) exp_q.push_back(32'(f));
    end
    check("ovr_set", 32'(ovr), 32'd1);
    check("ovr_level5", 32'(fifo_level), 32'd4);
    check("ovr_done", 32'(rx_done), 32'd1);
    for (int i = 0; i < 4; i++) rd_pulse();
    check("ovr_drained", 32'(fifo_empty), 32'd1);
    rd_pulse();
    check("rd_empty_level", 32'(fifo_level), 32'd0);
    check("rd_empty_data", rd_data, 32'h0);
    check("ovr_still", 32'(ovr), 32'd1);
    ovr_clr = 1'b1;
    @(posedge clk_rx);
    #1;
    ovr_clr = 1'b0;
    check("ovr_cleared", 32'(ovr), 32'd0);

    // CRC: data 0x01, CRC-8 poly 0x07 -> expected CRC 0x07, then corrupt 0x06
    for (int pass = 0; pass < 2; pass++) begin
      tnum_max = 13'd1;
      crc_en = 1'b1;
      crc_poly = 32'h0000_0007;
      do_reset(pass == 0 ? "rst_crc_ok" : "rst_crc_bad");
      send_frame(32'h01, 7, 1'b0, 1'b0);
      exp_q.push_back(32'h01);
      check("crc_mid_done", 32'(rx_done), CRC_BUILT ? 32'd0 : 32'd1);
      send_frame(pass == 0 ? 32'h07 : 32'h06, 7, 1'b0, 1'b0);
      check("crc_err", 32'(crc_err), (CRC_BUILT && pass == 1) ? 32'd1 : 32'd0);
      check("crc_done", 32'(rx_done), 32'd1);
      check("crc_level", 32'(fifo_level), 32'd1);
      rd_pulse();
      check("crc_only_data", 32'(fifo_empty), 32'd1);
    end
    crc_en = 1'b0;

    // tnum_max = 0 stays in S_DATA; reset mid-frame discards partial bits
    tnum_max = 13'd0;
    do_reset("rst3");
    send_frame(32'h55, 7, 1'b0, 1'b0);
    send_frame(32'h66, 7, 1'b0, 1'b0);
    check("unlim_not_done", 32'(rx_done), 32'd0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 7, 1'b0);
    check("partial_busy", 32'(rx_busy), 32'd1);
    do_reset("rst_mid");
    tnum_max = 13'd1;
    send_frame(32'h3C, 7, 1'b0, 1'b0);
    check("resync_head", rd_data, 32'h0000_003C);
    exp_q.push_back(32'h3C);
    rd_pulse();

    // Full FIFO with rd_en high on the edge completing a push
    tnum_max = 13'd5;
    do_reset("rst4");
    for (int f = 0; f < 5; f++) begin
      send_frame(32'h11 + 32'(f), 7, 1'b0, f == 4);
      exp_q.push_back(32'h11 + 32'(f));
    end
    check("pp_level", 32'(fifo_level), 32'd4);
    check("pp_full", 32'(fifo_full), 32'd1);
    check("pp_ovr", 32'(ovr), 32'd0);
    for (int i = 0; i < 4; i++) rd_pulse();
    check("pp_drained", 32'(fifo_empty), 32'd1);

    @(negedge clk_rx);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx_framer.md
SPI_RX_FRAMER -- requirements
Module: spi_rx_framer

Interface
REQ-001 SHALL have parameter DW_MAX, default 32: widest frame, legal 8..32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, 2..16.
REQ-003 SHALL have port clk_rx, input, 1: receive shift clock, one bit sampled per rising edge.
REQ-004 SHALL have port spi_rx_rstn, input, 1: reset, asynchronous, active-low; also acts as the frame-sync restart.
REQ-005 SHALL have port shift_in, input, 1: serial data bit.
REQ-006 SHALL have port dsize, input, 5: frame length minus 1, legal 3..DW_MAX-1.
REQ-007 SHALL have port lsbf, input, 1: 1 = first bit received is bit 0.
REQ-008 SHALL have port tnum_max, input, 13: data frames per transfer; 0 = unlimited.
REQ-009 SHALL have port crc_en, input, 1: a CRC frame follows the data frames.
REQ-010 SHALL have port crc_poly, input, 32: CRC polynomial, low dsize+1 bits used.
REQ-011 SHALL have port rd_en, input, 1: pop the FIFO head.
REQ-012 SHALL have port ovr_clr, input, 1: clear ovr.
REQ-013 SHALL have port rd_data, output, DW_MAX: FIFO head, right-aligned, zero-extended.
REQ-014 SHALL have outputs fifo_empty (1), fifo_full (1) and fifo_level ($clog2(FIFO_DEPTH)+1) for FIFO status.
REQ-015 SHALL have outputs ovr, crc_err, rx_done and rx_busy, each 1 bit: status flags.

Function
REQ-016 SHALL use a state machine S_DATA -> S_CRC -> S_DONE; reset state is S_DATA.
REQ-017 SHALL latch dsize and lsbf at bit 0 of each frame; changes mid-frame take effect at the next frame.
REQ-018 SHALL assemble MSB-first when lsbf=0: each bit shifts in at LSB, first bit ends at bit dsize; when lsbf=1, bit k received lands at position k.
REQ-019 SHALL push the completed data frame into the FIFO on the edge sampling its last bit; fifo_empty deasserts and rd_data is valid after that edge.
REQ-020 SHALL drop a push with the FIFO full and rd_en=0, and set ovr sticky; FIFO contents SHALL be unchanged.
REQ-021 SHALL accept push and pop together when full, with level unchanged.
REQ-022 SHALL ignore rd_en while empty; a pop SHALL advance rd_data on the next edge.
REQ-023 SHALL clear ovr on ovr_clr; a simultaneous overrun SHALL win and leave ovr set.
REQ-024 SHALL go from S_DATA to S_CRC (crc_en=1) or S_DONE (crc_en=0) after tnum_max frames; tnum_max=0 SHALL never leave S_DATA.
REQ-025 SHALL receive one frame of dsize+1 bits in S_CRC without pushing it; it is compared to the running CRC and crc_err set on mismatch, then S_DONE.
REQ-026 SHALL use a serial CRC: non-reflected, init 0, width dsize+1, updated with every data-frame bit in S_DATA.
REQ-027 SHALL hold rx_done=1 in S_DONE and ignore shift_in there; FIFO reads SHALL still work.
REQ-028 SHALL drive rx_busy=1 while a frame is partly received (bit counter non-zero).

Reset
REQ-029 SHALL on spi_rx_rstn low clear the FIFO, counters, CRC, state (S_DATA) and all flags; rd_data=0, fifo_empty=1, others 0.
REQ-030 SHALL discard a partial frame on reset mid-frame; the next bit after release is bit 0.

Configuration
REQ-031 SHALL compile in the CRC logic, S_CRC and crc_err when SPI_RX_FRAMER_CRC_EN is defined.
REQ-032 SHALL, without SPI_RX_FRAMER_CRC_EN, ignore crc_en and crc_poly, tie crc_err to 0, and go S_DATA -> S_DONE directly.

Structure
REQ-033 SHALL take the state enum, DW_MAX limits and the frame-length helper from package spi_rx_pkg.
REQ-034 SHALL instantiate the FIFO as sub-module spi_rx_fifo (parameters DW_MAX, FIFO_DEPTH); the CRC SHALL stay inline.

Verification
REQ-035 SHALL cover: dsize=7, lsbf=0, bits 1,0,1,0,0,1,0,1 -> rd_data=0x000000A5, fifo_empty=0 after 8th edge.
REQ-036 SHALL cover: dsize=11, lsbf=1, value 0xABC sent bit0 first -> rd_data=0x00000ABC.
REQ-037 SHALL cover: FIFO_DEPTH=4, five 8-bit frames 0x01..0x05, no reads -> ovr=1, reads return 0x01..0x04; ovr_clr -> ovr=0.
REQ-038 SHALL cover: dsize=7, crc_poly=0x07, tnum_max=1, crc_en=1, data 0x01 then CRC 0x07 -> crc_err=0, rx_done=1, FIFO holds only 0x01; repeat with CRC 0x06 -> crc_err=1.
REQ-039 SHALL cover: reset after 5 bits of a frame -> all outputs at reset values; next 8 bits 0x3C -> rd_data=0x3C.
REQ-040 SHALL cover: full FIFO with rd_en high while a push completes -> fifo_level stays 4, ovr=0.
